// File: rtl/jtcontra_gfxrom_pkg.sv
// jtcontra_gfxrom_pkg
//   Shared constants for the gfx ROM responder: arbiter FSM state codes and
//   client indices used by the round-robin pointer and slot selection.
package jtcontra_gfxrom_pkg;

    // Arbiter FSM state encodings
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] WAIT_RDY = 2'd2;

    // Client indices
    localparam logic GFX1 = 1'b0;
    localparam logic GFX2 = 1'b1;

endpackage

// File: rtl/jtcontra_gfxrom_slot.sv
// jtcontra_gfxrom_slot
//   One cached 16-bit word for a gfx ROM client. Answers hits combinationally
//   and flags a miss when the client requests an address that is not cached
//   and the slot is not already being fetched.
// Ports:
//   clk, rstn          clock, async active-low reset
//   addr, cs           client word address and request level
//   busy               this slot's fetch is currently in flight
//   fill               write fill_addr/fill_data into the slot and mark valid
//   data               cached word, always driven
//   ok                 data is valid for the current addr
//   miss               slot needs a fetch
module jtcontra_gfxrom_slot #(
    parameter int unsigned AW = 18
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] addr,
    input  logic          cs,
    input  logic          busy,
    input  logic          fill,
    input  logic [AW-1:0] fill_addr,
    input  logic [15:0]   fill_data,
    output logic [15:0]   data,
    output logic          ok,
    output logic          miss
);

    logic [AW-1:0] caddr;
    logic          valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            caddr <= '0;
            data  <= '0;
            valid <= 1'b0;
        end else if (fill) begin
            caddr <= fill_addr;
            data  <= fill_data;
            valid <= 1'b1;
        end
    end

    always_comb begin
        ok   = cs & valid & (caddr == addr);
        miss = cs & ~ok & ~busy;
    end

endmodule

// File: rtl/jtcontra_gfxrom_resp.sv
// jtcontra_gfxrom_resp
//   Responder for the two gfx ROM read ports. Each client has a one-word
//   cache slot; misses are arbitrated round-robin onto a single SDRAM read
//   channel using a req/ack/rdy handshake.
// Ports:
//   clk, rstn                         clock, async active-low reset
//   gfx1_addr/cs -> gfx1_data/ok      client 1 read port
//   gfx2_addr/cs -> gfx2_data/ok      client 2 read port
//   sdram_addr, sdram_req             read request, held until sdram_ack
//   sdram_ack, sdram_rdy, sdram_dout  accept pulse, data-valid pulse, data
module jtcontra_gfxrom_resp
    import jtcontra_gfxrom_pkg::*;
#(
    parameter int unsigned    AW    = 18,
    parameter int unsigned    SDW   = 22,
    parameter logic [SDW-1:0] BASE1 = 22'h00_0000,
    parameter logic [SDW-1:0] BASE2 = 22'h04_0000
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic [AW-1:0]  gfx1_addr,
    input  logic           gfx1_cs,
    output logic [15:0]    gfx1_data,
    output logic           gfx1_ok,
    input  logic [AW-1:0]  gfx2_addr,
    input  logic           gfx2_cs,
    output logic [15:0]    gfx2_data,
    output logic           gfx2_ok,
    output logic [SDW-1:0] sdram_addr,
    output logic           sdram_req,
    input  logic           sdram_ack,
    input  logic           sdram_rdy,
    input  logic [15:0]    sdram_dout
);

    logic [1:0]     st;
    logic           sel;         // client being fetched
    logic           rr;          // client favoured on a simultaneous miss
    logic [AW-1:0]  fetch_addr;  // address the fill is stored under

    logic           miss1, miss2;
    logic           busy1, busy2;
    logic           fill, fill1, fill2;
    logic           pick;
    logic [AW-1:0]  pick_addr;
    logic [SDW-1:0] pick_sdaddr;

    always_comb begin
        busy1 = (st != IDLE) & (sel == GFX1);
        busy2 = (st != IDLE) & (sel == GFX2);
        // ack and rdy may coincide, completing the fetch straight from WAIT_ACK
        fill  = ((st == WAIT_RDY) & sdram_rdy) |
                ((st == WAIT_ACK) & sdram_ack & sdram_rdy);
        fill1 = fill & (sel == GFX1);
        fill2 = fill & (sel == GFX2);

        if (miss1 & miss2) pick = rr;
        else               pick = miss2 ? GFX2 : GFX1;
        pick_addr   = (pick == GFX2) ? gfx2_addr : gfx1_addr;
        // sum wraps modulo 2^SDW
        pick_sdaddr = ((pick == GFX2) ? BASE2 : BASE1) +
                      {{(SDW-AW){1'b0}}, pick_addr};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st         <= IDLE;
            sel        <= GFX1;
            rr         <= GFX1;
            fetch_addr <= '0;
            sdram_addr <= '0;
            sdram_req  <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (miss1 | miss2) begin
                        sel        <= pick;
                        fetch_addr <= pick_addr;
                        sdram_addr <= pick_sdaddr;
                        sdram_req  <= 1'b1;
                        st         <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (sdram_rdy) begin
                            rr <= ~sel;
                            st <= IDLE;
                        end else begin
                            st <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (sdram_rdy) begin
                        rr <= ~sel;
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    jtcontra_gfxrom_slot #(.AW(AW)) u_slot1 (
        .clk       (clk),
        .rstn      (rstn),
        .addr      (gfx1_addr),
        .cs        (gfx1_cs),
        .busy      (busy1),
        .fill      (fill1),
        .fill_addr (fetch_addr),
        .fill_data (sdram_dout),
        .data      (gfx1_data),
        .ok        (gfx1_ok),
        .miss      (miss1)
    );

    jtcontra_gfxrom_slot #(.AW(AW)) u_slot2 (
        .clk       (clk),
        .rstn      (rstn),
        .addr      (gfx2_addr),
        .cs        (gfx2_cs),
        .busy      (busy2),
        .fill      (fill2),
        .fill_addr (fetch_addr),
        .fill_data (sdram_dout),
        .data      (gfx2_data),
        .ok        (gfx2_ok),
        .miss      (miss2)
    );

endmodule

// File: tb/tb_jtcontra_gfxrom_resp.sv
module tb_jtcontra_gfxrom_resp;

    logic        clk = 1'b0;
    logic        rstn;
    logic [17:0] gfx1_addr, gfx2_addr;
    logic        gfx1_cs, gfx2_cs;
    logic [15:0] gfx1_data, gfx2_data;
    logic        gfx1_ok, gfx2_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req, sdram_ack, sdram_rdy;
    logic [15:0] sdram_dout;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    jtcontra_gfxrom_resp dut (
        .clk        (clk),
        .rstn       (rstn),
        .gfx1_addr  (gfx1_addr),
        .gfx1_cs    (gfx1_cs),
        .gfx1_data  (gfx1_data),
        .gfx1_ok    (gfx1_ok),
        .gfx2_addr  (gfx2_addr),
        .gfx2_cs    (gfx2_cs),
        .gfx2_data  (gfx2_data),
        .gfx2_ok    (gfx2_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_rdy  (sdram_rdy),
        .sdram_dout (sdram_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cs1;
        logic [17:0] a1;
        logic        cs2;
        logic [17:0] a2;
        logic        ack;
        logic        rdy;
        logic [15:0] dout;
        logic        e_req;
        logic [21:0] e_addr;
        logic        e_ok1;
        logic [15:0] e_d1;
        logic        e_ok2;
        logic [15:0] e_d2;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(logic cs1, logic [17:0] a1, logic cs2, logic [17:0] a2,
                                logic ack, logic rdy, logic [15:0] dout,
                                logic e_req, logic [21:0] e_addr,
                                logic e_ok1, logic [15:0] e_d1,
                                logic e_ok2, logic [15:0] e_d2);
        vec_t v;
        v.cs1 = cs1; v.a1 = a1; v.cs2 = cs2; v.a2 = a2;
        v.ack = ack; v.rdy = rdy; v.dout = dout;
        v.e_req = e_req; v.e_addr = e_addr;
        v.e_ok1 = e_ok1; v.e_d1 = e_d1; v.e_ok2 = e_ok2; v.e_d2 = e_d2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a request, checks its address, then acks and delivers data.
    task automatic serve(input string name, input logic [21:0] exp_addr, input logic [15:0] data);
        for (int i = 0; i < 8; i++) begin
            if (sdram_req) break;
            step();
        end
        chk({name, "_req"}, {31'd0, sdram_req}, 32'd1);
        chk({name, "_addr"}, {10'd0, sdram_addr}, {10'd0, exp_addr});
        sdram_ack = 1'b1;
        step();
        sdram_ack  = 1'b0;
        sdram_rdy  = 1'b1;
        sdram_dout = data;
        step();
        sdram_rdy  = 1'b0;
        sdram_dout = 16'h0000;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Test 1: reset
        rstn = 1'b0;
        gfx1_cs = 1'b1; gfx1_addr = 18'h00123;
        gfx2_cs = 1'b1; gfx2_addr = 18'h00456;
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = 16'h0000;
        step(); step(); step();
        chk("rst_req",  {31'd0, sdram_req}, 32'd0);
        chk("rst_addr", {10'd0, sdram_addr}, 32'd0);
        chk("rst_ok1",  {31'd0, gfx1_ok}, 32'd0);
        chk("rst_ok2",  {31'd0, gfx2_ok}, 32'd0);
        chk("rst_d1",   {16'd0, gfx1_data}, 32'd0);
        chk("rst_d2",   {16'd0, gfx2_data}, 32'd0);
        gfx1_cs = 1'b0; gfx2_cs = 1'b0;
        gfx1_addr = '0; gfx2_addr = '0;
        rstn = 1'b1;
        step(); step(); step();
        chk("idle_req", {31'd0, sdram_req}, 32'd0);

        // Tests 2, 3, 6 and hit-during-fetch, cycle by cycle
        vecs[0]  = mk(1, 18'h00123, 0, 18'h0, 0, 0, 16'h0000, 0, 22'h000000, 0, 16'h0000, 0, 16'h0000);
        vecs[1]  = mk(1, 18'h00123, 0, 18'h0, 0, 0, 16'h0000, 1, 22'h000123, 0, 16'h0000, 0, 16'h0000);
        vecs[2]  = mk(1, 18'h00123, 0, 18'h0, 1, 0, 16'h0000, 1, 22'h000123, 0, 16'h0000, 0, 16'h0000);
        vecs[3]  = mk(1, 18'h00123, 0, 18'h0, 0, 0, 16'h0000, 0, 22'h000123, 0, 16'h0000, 0, 16'h0000);
        vecs[4]  = mk(1, 18'h00123, 0, 18'h0, 0, 1, 16'hBEEF, 0, 22'h000123, 0, 16'h0000, 0, 16'h0000);
        vecs[5]  = mk(1, 18'h00123, 0, 18'h0, 0, 0, 16'h0000, 0, 22'h000123, 1, 16'hBEEF, 0, 16'h0000);
        vecs[6]  = mk(1, 18'h00123, 0, 18'h0, 0, 0, 16'h0000, 0, 22'h000123, 1, 16'hBEEF, 0, 16'h0000);
        vecs[7]  = mk(1, 18'h00123, 0, 18'h0, 0, 1, 16'hDEAD, 0, 22'h000123, 1, 16'hBEEF, 0, 16'h0000);
        vecs[8]  = mk(1, 18'h00123, 0, 18'h0, 0, 0, 16'h0000, 0, 22'h000123, 1, 16'hBEEF, 0, 16'h0000);
        vecs[9]  = mk(1, 18'h3FFFF, 0, 18'h0, 0, 0, 16'h0000, 0, 22'h000123, 0, 16'hBEEF, 0, 16'h0000);
        vecs[10] = mk(1, 18'h3FFFF, 0, 18'h0, 1, 1, 16'h1234, 1, 22'h03FFFF, 0, 16'hBEEF, 0, 16'h0000);
        vecs[11] = mk(1, 18'h3FFFF, 0, 18'h0, 0, 0, 16'h0000, 0, 22'h03FFFF, 1, 16'h1234, 0, 16'h0000);
        vecs[12] = mk(1, 18'h3FFFF, 1, 18'h5, 0, 0, 16'h0000, 0, 22'h03FFFF, 1, 16'h1234, 0, 16'h0000);
        vecs[13] = mk(1, 18'h3FFFF, 1, 18'h5, 1, 0, 16'h0000, 1, 22'h040005, 1, 16'h1234, 0, 16'h0000);
        vecs[14] = mk(1, 18'h3FFFF, 1, 18'h5, 0, 1, 16'h5555, 0, 22'h040005, 1, 16'h1234, 0, 16'h0000);
        vecs[15] = mk(0, 18'h3FFFF, 1, 18'h5, 0, 0, 16'h0000, 0, 22'h040005, 0, 16'h1234, 1, 16'h5555);

        for (int i = 0; i < 16; i++) begin
            gfx1_cs = vecs[i].cs1; gfx1_addr = vecs[i].a1;
            gfx2_cs = vecs[i].cs2; gfx2_addr = vecs[i].a2;
            sdram_ack = vecs[i].ack; sdram_rdy = vecs[i].rdy; sdram_dout = vecs[i].dout;
            #1;
            chk($sformatf("v%0d_req", i),  {31'd0, sdram_req},  {31'd0, vecs[i].e_req});
            chk($sformatf("v%0d_addr", i), {10'd0, sdram_addr}, {10'd0, vecs[i].e_addr});
            chk($sformatf("v%0d_ok1", i),  {31'd0, gfx1_ok},    {31'd0, vecs[i].e_ok1});
            chk($sformatf("v%0d_d1", i),   {16'd0, gfx1_data},  {16'd0, vecs[i].e_d1});
            chk($sformatf("v%0d_ok2", i),  {31'd0, gfx2_ok},    {31'd0, vecs[i].e_ok2});
            chk($sformatf("v%0d_d2", i),   {16'd0, gfx2_data},  {16'd0, vecs[i].e_d2});
            step();
        end
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = 16'h0000;

        // Test 4: simultaneous misses and round-robin alternation
        gfx1_cs = 1'b0; gfx2_cs = 1'b0;
        rstn = 1'b0;
        step(); step();
        rstn = 1'b1;
        gfx1_cs = 1'b1; gfx1_addr = 18'h00200;
        gfx2_cs = 1'b1; gfx2_addr = 18'h00300;
        step();
        serve("rr_first", 22'h000200, 16'h1111);
        chk("rr_ok1a", {31'd0, gfx1_ok}, 32'd1);
        chk("rr_d1a",  {16'd0, gfx1_data}, 32'h1111);
        chk("rr_ok2a", {31'd0, gfx2_ok}, 32'd0);
        serve("rr_second", 22'h040300, 16'h2222);
        chk("rr_ok2b", {31'd0, gfx2_ok}, 32'd1);
        chk("rr_d2b",  {16'd0, gfx2_data}, 32'h2222);
        gfx1_addr = 18'h00201; gfx2_addr = 18'h00301;
        step();
        serve("rr_pair2a", 22'h000201, 16'h3333);
        serve("rr_pair2b", 22'h040301, 16'h4444);
        chk("rr_d1c", {16'd0, gfx1_data}, 32'h3333);
        chk("rr_d2c", {16'd0, gfx2_data}, 32'h4444);
        // gfx1 alone, then a pair: gfx2 must now win
        gfx1_addr = 18'h00202;
        step();
        serve("rr_solo", 22'h000202, 16'h5151);
        gfx1_addr = 18'h00203; gfx2_addr = 18'h00302;
        step();
        serve("rr_pair3a", 22'h040302, 16'h6262);
        serve("rr_pair3b", 22'h000203, 16'h7373);
        chk("rr_ok1d", {31'd0, gfx1_ok}, 32'd1);
        chk("rr_ok2d", {31'd0, gfx2_ok}, 32'd1);

        // Test 5: gfx2 address changes during WAIT_RDY
        gfx1_cs = 1'b0;
        gfx2_addr = 18'h00010;
        step();
        chk("chg_req",  {31'd0, sdram_req}, 32'd1);
        chk("chg_addr", {10'd0, sdram_addr}, 32'h040010);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        gfx2_addr = 18'h00011;
        step();
        sdram_rdy = 1'b1; sdram_dout = 16'hAAAA;
        step();
        sdram_rdy = 1'b0; sdram_dout = 16'h0000;
        #1;
        chk("chg_ok_stale", {31'd0, gfx2_ok}, 32'd0);
        chk("chg_d_stale",  {16'd0, gfx2_data}, 32'h0000AAAA);
        serve("chg_refetch", 22'h040011, 16'hBBBB);
        chk("chg_ok",   {31'd0, gfx2_ok}, 32'd1);
        chk("chg_data", {16'd0, gfx2_data}, 32'h0000BBBB);

        // Test 7: reset in WAIT_RDY, late ack/rdy ignored
        gfx1_cs = 1'b1; gfx1_addr = 18'h00500;
        step();
        chk("rst7_req", {31'd0, sdram_req}, 32'd1);
        sdram_ack = 1'b1;
        step();
        sdram_ack = 1'b0;
        chk("rst7_ok2_pre", {31'd0, gfx2_ok}, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst7_req0", {31'd0, sdram_req}, 32'd0);
        chk("rst7_ok2",  {31'd0, gfx2_ok}, 32'd0);
        chk("rst7_d1",   {16'd0, gfx1_data}, 32'd0);
        step();
        rstn = 1'b1;
        gfx1_cs = 1'b0; gfx2_cs = 1'b0;
        step();
        sdram_ack = 1'b1; sdram_rdy = 1'b1; sdram_dout = 16'hDEAD;
        step();
        sdram_ack = 1'b0; sdram_rdy = 1'b0; sdram_dout = 16'h0000;
        gfx1_cs = 1'b1; gfx1_addr = 18'h00500;
        #1;
        chk("rst7_ok1_late", {31'd0, gfx1_ok}, 32'd0);
        chk("rst7_d1_late",  {16'd0, gfx1_data}, 32'd0);
        chk("rst7_req_late", {31'd0, sdram_req}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
